// File: rtl/wb_pkg.sv
// Shared types for the wishbone master selector: FSM state encoding,
// master count and the grant index type consumed from the arbiter.
package wb_pkg;

    localparam int NUM_MSTR = 4;
    localparam int GNT_W    = 2;

    typedef logic [GNT_W-1:0] gnt_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    function automatic logic [NUM_MSTR-1:0] onehot(input gnt_t idx);
        return NUM_MSTR'(1) << idx;
    endfunction

endpackage

// File: rtl/wb_mstr_sel_if.sv
// Bus bundle between the four masters, the arbiter grant and the shared slave.
// Master side: m_stb_i[n] stays high until master n sees its one-cycle ack or err pulse;
// slave side: s_cyc_o/s_stb_o stay high and s_* stay stable until s_ack_i or s_err_i.
interface wb_mstr_sel_if
    import wb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
);
    gnt_t                       gnt;
    logic [NUM_MSTR-1:0]        m_stb_i;
    logic [NUM_MSTR-1:0]        m_we_i;
    logic [NUM_MSTR*AW-1:0]     m_adr_i;
    logic [NUM_MSTR*DW-1:0]     m_dat_i;
    logic [NUM_MSTR*DW/8-1:0]   m_sel_i;
    logic [DW-1:0]              m_dat_o;
    logic [NUM_MSTR-1:0]        m_ack_o;
    logic [NUM_MSTR-1:0]        m_err_o;
    logic                       s_cyc_o;
    logic                       s_stb_o;
    logic                       s_we_o;
    logic [AW-1:0]              s_adr_o;
    logic [DW-1:0]              s_dat_o;
    logic [DW/8-1:0]            s_sel_o;
    logic [DW-1:0]              s_dat_i;
    logic                       s_ack_i;
    logic                       s_err_i;
    state_t                     fsm_state;

    modport slave (
        input  gnt, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
        input  s_dat_i, s_ack_i, s_err_i,
        output m_dat_o, m_ack_o, m_err_o,
        output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
        output fsm_state
    );

    modport master (
        output gnt, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
        output s_dat_i, s_ack_i, s_err_i,
        input  m_dat_o, m_ack_o, m_err_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
        input  fsm_state
    );

endinterface

// File: rtl/wb_tmo_cnt.sv
// Timeout counter for an outstanding slave cycle; holds at all-ones so it
// can never wrap back while the owner is still waiting.
module wb_tmo_cnt #(
    parameter int TMO_W = 8
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    logic [TMO_W-1:0] cnt;

    assign expired = (cnt == {TMO_W{1'b1}});

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/wb_mstr_sel.sv
// Routes the granted master's request onto the shared slave bus, one cycle at a time,
// and returns ack/err/read data to the owning master only. Aborts silent slaves with err.
module wb_mstr_sel
    import wb_pkg::*;
#(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int TMO_W = 8
) (
    input logic            clk,
    input logic            rstn,
    wb_mstr_sel_if.slave   bus
);

    localparam int SW = DW / 8;

    state_t              state, state_nxt;
    gnt_t                owner, owner_nxt;
    logic                cyc_nxt, stb_nxt, we_nxt;
    logic [AW-1:0]       adr_nxt;
    logic [DW-1:0]       dat_nxt, mdat_nxt;
    logic [SW-1:0]       sel_nxt;
    logic [NUM_MSTR-1:0] ack_nxt, err_nxt;
    logic                tmo_inc, tmo_clr, tmo_expired;

    wb_tmo_cnt #(.TMO_W(TMO_W)) u_tmo (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (tmo_clr),
        .inc     (tmo_inc),
        .expired (tmo_expired)
    );

    assign bus.fsm_state = state;

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        cyc_nxt   = bus.s_cyc_o;
        stb_nxt   = bus.s_stb_o;
        we_nxt    = bus.s_we_o;
        adr_nxt   = bus.s_adr_o;
        dat_nxt   = bus.s_dat_o;
        sel_nxt   = bus.s_sel_o;
        mdat_nxt  = bus.m_dat_o;
        ack_nxt   = '0;
        err_nxt   = '0;
        tmo_inc   = 1'b0;
        tmo_clr   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.m_stb_i[bus.gnt]) begin
                    owner_nxt = bus.gnt;
                    we_nxt    = bus.m_we_i[bus.gnt];
                    adr_nxt   = bus.m_adr_i[bus.gnt*AW +: AW];
                    dat_nxt   = bus.m_dat_i[bus.gnt*DW +: DW];
                    sel_nxt   = bus.m_sel_i[bus.gnt*SW +: SW];
                    cyc_nxt   = 1'b1;
                    stb_nxt   = 1'b1;
                    // Counting the launch cycle makes the abort land after 2**TMO_W-1 ISSUE cycles.
                    tmo_inc   = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.s_err_i) begin
                    cyc_nxt   = 1'b0;
                    stb_nxt   = 1'b0;
                    err_nxt   = onehot(owner);
                    state_nxt = RESP;
                end else if (bus.s_ack_i) begin
                    cyc_nxt   = 1'b0;
                    stb_nxt   = 1'b0;
                    mdat_nxt  = bus.s_dat_i;
                    ack_nxt   = onehot(owner);
                    state_nxt = RESP;
                end else if (tmo_expired) begin
                    cyc_nxt   = 1'b0;
                    stb_nxt   = 1'b0;
                    err_nxt   = onehot(owner);
                    state_nxt = RESP;
                end else begin
                    tmo_inc   = 1'b1;
                end
            end
            RESP: begin
                tmo_clr   = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                tmo_clr   = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            owner       <= '0;
            bus.s_cyc_o <= 1'b0;
            bus.s_stb_o <= 1'b0;
            bus.s_we_o  <= 1'b0;
            bus.s_adr_o <= '0;
            bus.s_dat_o <= '0;
            bus.s_sel_o <= '0;
            bus.m_dat_o <= '0;
            bus.m_ack_o <= '0;
            bus.m_err_o <= '0;
        end else begin
            owner       <= owner_nxt;
            bus.s_cyc_o <= cyc_nxt;
            bus.s_stb_o <= stb_nxt;
            bus.s_we_o  <= we_nxt;
            bus.s_adr_o <= adr_nxt;
            bus.s_dat_o <= dat_nxt;
            bus.s_sel_o <= sel_nxt;
            bus.m_dat_o <= mdat_nxt;
            bus.m_ack_o <= ack_nxt;
            bus.m_err_o <= err_nxt;
        end
    end

endmodule

// File: tb/tb_wb_mstr_sel.sv
// Directed bench for wb_mstr_sel: table of single transfers plus hand sequences
// for reset, timeout, late responses and grant switching.
module tb_wb_mstr_sel;
    import wb_pkg::*;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    wb_mstr_sel_if #(.AW(32), .DW(32)) bus ();

    wb_mstr_sel #(.AW(32), .DW(32), .TMO_W(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0]  gnt;
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          delay;
        logic        s_ack;
        logic        s_err;
        logic [31:0] rdata;
        logic        drop_early;
        logic [3:0]  exp_ack;
        logic [3:0]  exp_err;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vecs[6];

    function automatic vec_t mk(input logic [1:0] g, input logic we, input logic [31:0] adr,
                                input logic [31:0] dat, input logic [3:0] sel, input int dly,
                                input logic ack, input logic err, input logic [31:0] rd,
                                input logic drop, input logic [3:0] eack, input logic [3:0] eerr,
                                input logic [31:0] edat);
        vec_t v;
        v.gnt = g; v.we = we; v.adr = adr; v.dat = dat; v.sel = sel; v.delay = dly;
        v.s_ack = ack; v.s_err = err; v.rdata = rd; v.drop_early = drop;
        v.exp_ack = eack; v.exp_err = eerr; v.exp_dat = edat;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.gnt     = '0;
        bus.m_stb_i = '0;
        bus.m_we_i  = '0;
        bus.m_adr_i = '0;
        bus.m_dat_i = '0;
        bus.m_sel_i = '0;
        bus.s_dat_i = '0;
        bus.s_ack_i = 1'b0;
        bus.s_err_i = 1'b0;
    endtask

    task automatic load_master(input int m, input logic we, input logic [31:0] adr,
                               input logic [31:0] dat, input logic [3:0] sel);
        bus.m_we_i[m]            = we;
        bus.m_adr_i[m*32 +: 32]  = adr;
        bus.m_dat_i[m*32 +: 32]  = dat;
        bus.m_sel_i[m*4 +: 4]    = sel;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int m;
        m = int'(v.gnt);
        load_master(m, v.we, v.adr, v.dat, v.sel);
        bus.gnt     = v.gnt;
        bus.m_stb_i = 4'(1) << m;
        @(negedge clk);
        check($sformatf("v%0d_launch", idx), {62'd0, bus.s_cyc_o, bus.s_stb_o}, 64'd3);
        check($sformatf("v%0d_adr", idx), 64'(bus.s_adr_o), 64'(v.adr));
        check($sformatf("v%0d_dat", idx), 64'(bus.s_dat_o), 64'(v.dat));
        check($sformatf("v%0d_we_sel", idx), {59'd0, bus.s_we_o, bus.s_sel_o}, {59'd0, v.we, v.sel});
        if (v.drop_early) bus.m_stb_i = '0;
        for (int i = 0; i < v.delay; i++) begin
            @(negedge clk);
            check($sformatf("v%0d_hold", idx), {62'd0, bus.s_stb_o, |(bus.m_ack_o | bus.m_err_o)}, 64'd2);
        end
        bus.s_ack_i = v.s_ack;
        bus.s_err_i = v.s_err;
        bus.s_dat_i = v.rdata;
        @(negedge clk);
        bus.s_ack_i = 1'b0;
        bus.s_err_i = 1'b0;
        check($sformatf("v%0d_ack", idx), 64'(bus.m_ack_o), 64'(v.exp_ack));
        check($sformatf("v%0d_err", idx), 64'(bus.m_err_o), 64'(v.exp_err));
        check($sformatf("v%0d_drop", idx), {62'd0, bus.s_cyc_o, bus.s_stb_o}, 64'd0);
        if (v.exp_ack != 4'd0) check($sformatf("v%0d_rdata", idx), 64'(bus.m_dat_o), 64'(v.exp_dat));
        bus.m_stb_i = '0;
        @(negedge clk);
        check($sformatf("v%0d_pulse_end", idx), {56'd0, bus.m_ack_o, bus.m_err_o}, 64'd0);
        check($sformatf("v%0d_idle", idx), 64'(bus.fsm_state), 64'(IDLE));
    endtask

    initial begin
        int cnt;
        vecs[0] = mk(2'd2, 1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF, 1, 1'b1, 1'b0, 32'h5555_0000, 1'b0, 4'b0100, 4'b0000, 32'h5555_0000);
        vecs[1] = mk(2'd1, 1'b0, 32'h1000_0004, 32'h0000_0000, 4'hF, 0, 1'b1, 1'b0, 32'h1234_5678, 1'b0, 4'b0010, 4'b0000, 32'h1234_5678);
        vecs[2] = mk(2'd0, 1'b1, 32'h0000_0100, 32'h0BAD_F00D, 4'h3, 2, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 4'b0000, 4'b0001, 32'h0000_0000);
        vecs[3] = mk(2'd3, 1'b0, 32'h4000_0000, 32'h0000_0000, 4'hC, 1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 4'b0000, 4'b1000, 32'h0000_0000);
        vecs[4] = mk(2'd1, 1'b1, 32'h1000_0008, 32'h1111_2222, 4'h1, 0, 1'b1, 1'b0, 32'hCAFE_0001, 1'b0, 4'b0010, 4'b0000, 32'hCAFE_0001);
        vecs[5] = mk(2'd0, 1'b0, 32'h0000_0200, 32'h0000_0000, 4'hF, 3, 1'b1, 1'b0, 32'hA5A5_5A5A, 1'b1, 4'b0001, 4'b0000, 32'hA5A5_5A5A);

        // Reset state
        clear_inputs();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_slave", {62'd0, bus.s_cyc_o, bus.s_stb_o}, 64'd0);
        check("rst_pulses", {56'd0, bus.m_ack_o, bus.m_err_o}, 64'd0);
        check("rst_mdat", 64'(bus.m_dat_o), 64'd0);
        check("rst_state", 64'(bus.fsm_state), 64'(IDLE));
        rstn = 1'b1;
        @(negedge clk);

        // Non-granted request is ignored
        load_master(1, 1'b1, 32'h2000_0000, 32'h1, 4'hF);
        bus.gnt     = 2'd0;
        bus.m_stb_i = 4'b0010;
        repeat (3) @(negedge clk);
        check("nogrant_stb", {62'd0, bus.s_cyc_o, bus.s_stb_o}, 64'd0);
        bus.m_stb_i = '0;

        // Late ack in IDLE
        bus.s_ack_i = 1'b1;
        @(negedge clk);
        bus.s_ack_i = 1'b0;
        @(negedge clk);
        check("late_idle_pulse", {56'd0, bus.m_ack_o, bus.m_err_o}, 64'd0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Timeout with silent slave
        load_master(1, 1'b0, 32'h2000_0040, 32'h0, 4'hF);
        bus.gnt     = 2'd1;
        bus.m_stb_i = 4'b0010;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.s_stb_o) break;
            cnt++;
        end
        check("tmo_cycles", 64'(cnt), 64'd15);
        check("tmo_err", 64'(bus.m_err_o), 64'(4'b0010));
        check("tmo_noack", 64'(bus.m_ack_o), 64'd0);
        bus.m_stb_i = '0;
        @(negedge clk);
        check("tmo_err_end", 64'(bus.m_err_o), 64'd0);
        bus.s_ack_i = 1'b1;
        @(negedge clk);
        bus.s_ack_i = 1'b0;
        check("tmo_late_ack1", {56'd0, bus.m_ack_o, bus.m_err_o}, 64'd0);
        @(negedge clk);
        check("tmo_late_ack2", {56'd0, bus.m_ack_o, bus.m_err_o}, 64'd0);

        // Grant switch during master0's ISSUE
        load_master(0, 1'b1, 32'h0000_0A00, 32'h0000_AAAA, 4'hF);
        load_master(3, 1'b1, 32'h3000_0B00, 32'h0000_BBBB, 4'h3);
        bus.gnt     = 2'd0;
        bus.m_stb_i = 4'b1001;
        @(negedge clk);
        check("gsw_m0_adr", 64'(bus.s_adr_o), 64'h0000_0A00);
        bus.gnt = 2'd3;
        repeat (2) @(negedge clk);
        check("gsw_m0_hold", 64'(bus.s_adr_o), 64'h0000_0A00);
        bus.s_ack_i = 1'b1;
        @(negedge clk);
        bus.s_ack_i = 1'b0;
        check("gsw_m0_ack", 64'(bus.m_ack_o), 64'(4'b0001));
        bus.m_stb_i = 4'b1000;
        @(negedge clk);
        check("gsw_idle", {60'd0, bus.m_ack_o}, 64'd0);
        @(negedge clk);
        check("gsw_m3_issue", {bus.s_adr_o, bus.s_dat_o}, {32'h3000_0B00, 32'h0000_BBBB});
        bus.s_ack_i = 1'b1;
        @(negedge clk);
        bus.s_ack_i = 1'b0;
        check("gsw_m3_ack", 64'(bus.m_ack_o), 64'(4'b1000));
        bus.m_stb_i = '0;
        repeat (3) @(negedge clk);
        check("gsw_no_dup", {61'd0, bus.s_stb_o, |bus.m_ack_o, |bus.m_err_o}, 64'd0);

        // Reset mid-ISSUE
        load_master(2, 1'b1, 32'h3000_0020, 32'h0000_1234, 4'hF);
        bus.gnt     = 2'd2;
        bus.m_stb_i = 4'b0100;
        @(negedge clk);
        check("rmid_issue", 64'(bus.s_stb_o), 64'd1);
        rstn = 1'b0;
        #1;
        check("rmid_slave", {62'd0, bus.s_cyc_o, bus.s_stb_o}, 64'd0);
        check("rmid_pulses", {56'd0, bus.m_ack_o, bus.m_err_o}, 64'd0);
        check("rmid_state", 64'(bus.fsm_state), 64'(IDLE));
        bus.m_stb_i = '0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        check("rmid_after", {54'd0, bus.s_cyc_o, bus.s_stb_o, bus.m_ack_o, bus.m_err_o}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
